// File: rtl/ac_ir_cmd_scheduler.sv
// AC IR command scheduler: owns power/mode/temp/fan, turns key pulses into
// frame words and sequences the IR transmitter with repeat, gap and timeout.
module ac_ir_cmd_scheduler #(
  parameter int          GAP_CYCLES     = 12500000,
  parameter int          TIMEOUT_CYCLES = 25000000,
  parameter int          REPEAT         = 1,
  parameter int          TEMP_RESET     = 26,
  parameter logic [22:0] CONST35        = 23'h040052,
  parameter logic [27:0] CONST32        = 28'h0002000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_power,
  input  logic        key_mode,
  input  logic        key_temp_up,
  input  logic        key_temp_down,
  input  logic        key_fan,
  output logic        tx_start,
  output logic [34:0] tx_data35,
  output logic [31:0] tx_data32,
  input  logic        tx_done,
  output logic        busy,
  output logic        err_timeout,
  output logic        cur_power,
  output logic [2:0]  cur_mode,
  output logic [4:0]  cur_temp,
  output logic [1:0]  cur_fan
);

  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  localparam int F_POWER = 0;
  localparam int F_MODE  = 1;
  localparam int F_UP    = 2;
  localparam int F_DOWN  = 3;
  localparam int F_FAN   = 4;

  typedef enum logic [2:0] {IDLE, APPLY, LOAD, WAIT_DONE, GAP} state_t;

  state_t         state_reg, state_next;
  logic [4:0]     flag_reg, flag_next, key_vec;
  logic           flag_clr;
  logic           power_reg, power_next;
  logic [2:0]     mode_reg, mode_next;
  logic [4:0]     temp_reg, temp_next;
  logic [1:0]     fan_reg, fan_next;
  logic [2:0]     rep_reg, rep_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           err_reg, err_next;
  logic           load_data;
  logic           tx_start_reg;
  logic [34:0]    tx_data35_reg;
  logic [31:0]    tx_data32_reg;
  logic [3:0]     tcode_next, chk_next;

  // Opposite temperature keys in the same cycle cancel each other.
  assign key_vec = {key_fan,
                    key_temp_down & ~key_temp_up,
                    key_temp_up & ~key_temp_down,
                    key_mode,
                    key_power};

  // A key arriving in APPLY wins over the clear so it is never lost.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_flag
      assign flag_next[gi] = (flag_reg[gi] & ~flag_clr) | key_vec[gi];
    end
  endgenerate

  assign tcode_next = 4'(temp_next - 5'd16);
  assign chk_next   = {1'b0, mode_next} + {3'b000, power_next} + {2'b00, fan_next} + tcode_next;

  always_comb begin
    state_next = state_reg;
    power_next = power_reg;
    mode_next  = mode_reg;
    temp_next  = temp_reg;
    fan_next   = fan_reg;
    rep_next   = rep_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    flag_clr   = 1'b0;
    load_data  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|flag_reg) state_next = APPLY;
      end
      APPLY: begin
        flag_clr   = 1'b1;
        power_next = power_reg ^ flag_reg[F_POWER];
        if (power_next) begin
          if (flag_reg[F_MODE]) mode_next = (mode_reg == 3'd4) ? 3'd0 : mode_reg + 3'd1;
          if (flag_reg[F_UP] && temp_next < 5'd30) temp_next = temp_next + 5'd1;
          if (flag_reg[F_DOWN] && temp_next > 5'd16) temp_next = temp_next - 5'd1;
          if (flag_reg[F_FAN]) fan_next = fan_reg + 2'd1;
        end
        // Keys pressed while powered off change nothing and send nothing.
        if (!power_reg && !flag_reg[F_POWER]) begin
          state_next = IDLE;
        end else begin
          rep_next   = 3'(REPEAT);
          load_data  = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        cnt_next   = '0;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          err_next   = 1'b0;
          rep_next   = rep_reg - 3'd1;
          cnt_next   = '0;
          state_next = GAP;
        end else if (cnt_reg == TO_LAST) begin
          err_next   = 1'b1;
          rep_next   = '0;
          cnt_next   = '0;
          state_next = GAP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next   = '0;
          state_next = (rep_reg != 3'd0) ? LOAD : IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      flag_reg      <= '0;
      power_reg     <= 1'b0;
      mode_reg      <= '0;
      temp_reg      <= 5'(TEMP_RESET);
      fan_reg       <= '0;
      rep_reg       <= '0;
      cnt_reg       <= '0;
      err_reg       <= 1'b0;
      tx_start_reg  <= 1'b0;
      tx_data35_reg <= '0;
      tx_data32_reg <= '0;
    end else begin
      state_reg    <= state_next;
      flag_reg     <= flag_next;
      power_reg    <= power_next;
      mode_reg     <= mode_next;
      temp_reg     <= temp_next;
      fan_reg      <= fan_next;
      rep_reg      <= rep_next;
      cnt_reg      <= cnt_next;
      err_reg      <= err_next;
      tx_start_reg <= (state_next == LOAD);
      // Words are built once per update and reused for every repeat.
      if (load_data) begin
        tx_data35_reg <= {mode_next, power_next, fan_next, 2'b00, tcode_next, CONST35};
        tx_data32_reg <= {CONST32, chk_next};
      end
    end
  end

  assign tx_start    = tx_start_reg;
  assign tx_data35   = tx_data35_reg;
  assign tx_data32   = tx_data32_reg;
  assign busy        = (state_reg != IDLE);
  assign err_timeout = err_reg;
  assign cur_power   = power_reg;
  assign cur_mode    = mode_reg;
  assign cur_temp    = temp_reg;
  assign cur_fan     = fan_reg;

endmodule

// File: tb/tb_ac_ir_cmd_scheduler.sv
// Bench for ac_ir_cmd_scheduler: two instances (REPEAT=1 and REPEAT=3) driven
// in lock-step against a transaction-level model of the AC state and frames.
module tb_ac_ir_cmd_scheduler;

  localparam int GAP = 8;
  localparam int TO  = 100;
  localparam int KP  = 128;

  localparam logic [4:0] K_PW   = 5'b00001;
  localparam logic [4:0] K_MODE = 5'b00010;
  localparam logic [4:0] K_UP   = 5'b00100;
  localparam logic [4:0] K_DOWN = 5'b01000;
  localparam logic [4:0] K_FAN  = 5'b10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        kp [2], km [2], ku [2], kd [2], kf [2], txd [2];
  logic        ts [2], busy_o [2], err_o [2], cpw [2];
  logic [34:0] d35 [2];
  logic [31:0] d32 [2];
  logic [2:0]  cmode [2];
  logic [4:0]  ctemp [2];
  logic [1:0]  cfan [2];

  ac_ir_cmd_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .REPEAT(1)) dut_r1 (
    .clk(clk), .rst(rst[0]), .key_power(kp[0]), .key_mode(km[0]),
    .key_temp_up(ku[0]), .key_temp_down(kd[0]), .key_fan(kf[0]),
    .tx_start(ts[0]), .tx_data35(d35[0]), .tx_data32(d32[0]), .tx_done(txd[0]),
    .busy(busy_o[0]), .err_timeout(err_o[0]), .cur_power(cpw[0]),
    .cur_mode(cmode[0]), .cur_temp(ctemp[0]), .cur_fan(cfan[0]));

  ac_ir_cmd_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .REPEAT(3)) dut_r3 (
    .clk(clk), .rst(rst[1]), .key_power(kp[1]), .key_mode(km[1]),
    .key_temp_up(ku[1]), .key_temp_down(kd[1]), .key_fan(kf[1]),
    .tx_start(ts[1]), .tx_data35(d35[1]), .tx_data32(d32[1]), .tx_done(txd[1]),
    .busy(busy_o[1]), .err_timeout(err_o[1]), .cur_power(cpw[1]),
    .cur_mode(cmode[1]), .cur_temp(ctemp[1]), .cur_fan(cfan[1]));

  // Reference model state, one slot per instance.
  bit          m_pw [2];
  int          m_mode [2], m_temp [2], m_fan [2];
  bit [4:0]    m_pend [2];
  logic [34:0] m_d35 [2];
  logic [31:0] m_d32 [2];
  bit [4:0]    kplan [KP];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [34:0] exp35(bit pw, int mode, int temp, int fan);
    return {3'(mode), pw, 2'(fan), 2'b00, 4'(temp - 16), 23'h040052};
  endfunction

  function automatic logic [31:0] exp32(bit pw, int mode, int temp, int fan);
    int s;
    s = mode + int'(pw) + fan + (temp - 16);
    return {28'h0002000, 4'(s % 16)};
  endfunction

  task automatic model_reset(int i);
    m_pw[i] = 1'b0; m_mode[i] = 0; m_temp[i] = 26; m_fan[i] = 0; m_pend[i] = '0;
  endtask

  // One clock: present inputs for a cycle, sample outputs on the next falling edge.
  task automatic step(int i, bit [4:0] k, bit dn);
    bit [4:0] eff;
    kp[i] = k[0]; km[i] = k[1]; ku[i] = k[2]; kd[i] = k[3]; kf[i] = k[4]; txd[i] = dn;
    @(negedge clk);
    kp[i] = 1'b0; km[i] = 1'b0; ku[i] = 1'b0; kd[i] = 1'b0; kf[i] = 1'b0; txd[i] = 1'b0;
    eff = k;
    if (k[2] && k[3]) eff[3:2] = 2'b00;
    m_pend[i] = m_pend[i] | eff;
  endtask

  task automatic check_cur(int i);
    check("cur_power", 64'(cpw[i]), 64'(m_pw[i]));
    check("cur_mode", 64'(cmode[i]), 64'(m_mode[i]));
    check("cur_temp", 64'(ctemp[i]), 64'(m_temp[i]));
    check("cur_fan", 64'(cfan[i]), 64'(m_fan[i]));
  endtask

  task automatic check_reset(int i);
    check("rst_tx_start", 64'(ts[i]), 64'd0);
    check("rst_d35", 64'(d35[i]), 64'd0);
    check("rst_d32", 64'(d32[i]), 64'd0);
    check("rst_busy", 64'(busy_o[i]), 64'd0);
    check("rst_err", 64'(err_o[i]), 64'd0);
    check_cur(i);
  endtask

  task automatic idle_quiet(int i, int n);
    for (int c = 0; c < n; c++) begin
      step(i, 5'd0, 1'b0);
      check("idle_start", 64'(ts[i]), 64'd0);
      check("idle_busy", 64'(busy_o[i]), 64'd0);
    end
  endtask

  // Called where flags are visible and the scheduler is idle; applies them and
  // checks the APPLY cycle and the LOAD cycle (or return to idle).
  task automatic apply(int i, output bit frame);
    bit [4:0] p;
    p = m_pend[i];
    frame = m_pw[i] || p[0];
    if (p[0]) m_pw[i] = !m_pw[i];
    if (m_pw[i]) begin
      if (p[1]) m_mode[i] = (m_mode[i] + 1) % 5;
      if (p[2] && m_temp[i] < 30) m_temp[i] = m_temp[i] + 1;
      if (p[3] && m_temp[i] > 16) m_temp[i] = m_temp[i] - 1;
      if (p[4]) m_fan[i] = (m_fan[i] + 1) % 4;
    end
    m_pend[i] = '0;
    step(i, 5'd0, 1'b0);
    check("apply_busy", 64'(busy_o[i]), 64'd1);
    check("apply_start", 64'(ts[i]), 64'd0);
    step(i, 5'd0, 1'b0);
    check("load_start", 64'(ts[i]), 64'(frame));
    check("load_busy", 64'(busy_o[i]), 64'(frame));
    check_cur(i);
    if (frame) begin
      m_d35[i] = exp35(m_pw[i], m_mode[i], m_temp[i], m_fan[i]);
      m_d32[i] = exp32(m_pw[i], m_mode[i], m_temp[i], m_fan[i]);
      check("load_d35", 64'(d35[i]), 64'(m_d35[i]));
      check("load_d32", 64'(d32[i]), 64'(m_d32[i]));
    end
    $display("[inst%0d t=%0t] apply flags=%b -> pw=%0d mode=%0d temp=%0d fan=%0d frame=%0d",
             i, $time, p, m_pw[i], m_mode[i], m_temp[i], m_fan[i], frame);
  endtask

  // Entered on the tx_start cycle. d=0 withholds tx_done (timeout), else tx_done
  // is returned in the d-th waiting cycle. kplan keys are injected during frame 1.
  task automatic serve(int i, int d, int stop_at, bit stray);
    bit to;
    int w, left, served;
    bit [4:0] k;
    bit dn;
    to = (d == 0);
    w = to ? TO : d;
    left = (i == 0) ? 1 : 3;
    served = 0;
    for (int r = 0; r < 3; r++) begin
      for (int s = 1; s <= w + GAP; s++) begin
        k = (r == 0) ? kplan[s] : 5'd0;
        dn = (!to && s == w + 1);
        if (stray && (s == 1 || s >= w + 2) && $urandom_range(0, 3) == 0) dn = 1'b1;
        step(i, k, dn);
        check("frame_start_quiet", 64'(ts[i]), 64'd0);
        check("frame_busy", 64'(busy_o[i]), 64'd1);
        if (s == w + 1) check("err_after_frame", 64'(err_o[i]), 64'(to));
      end
      for (int s = 0; s < KP; s++) kplan[s] = 5'd0;
      left = to ? 0 : left - 1;
      served++;
      step(i, 5'd0, 1'b0);
      if (left > 0) begin
        check("repeat_start", 64'(ts[i]), 64'd1);
        check("repeat_d35", 64'(d35[i]), 64'(m_d35[i]));
        check("repeat_d32", 64'(d32[i]), 64'(m_d32[i]));
        check("repeat_busy", 64'(busy_o[i]), 64'd1);
        $display("[inst%0d t=%0t] repeat frame %0d", i, $time, served + 1);
        if (served == stop_at) return;
      end else begin
        check("end_start_quiet", 64'(ts[i]), 64'd0);
        check("end_busy", 64'(busy_o[i]), 64'd0);
        $display("[inst%0d t=%0t] frame done timeout=%0d", i, $time, to);
        return;
      end
    end
  endtask

  task automatic key_frame(int i, bit [4:0] k, int d);
    bit fr;
    step(i, k, 1'b0);
    apply(i, fr);
    if (fr) serve(i, d, 0, 1'b0);
  endtask

  task automatic random_run(int i, int iters);
    bit [4:0] k;
    bit fr;
    int d;
    for (int it = 0; it < iters; it++) begin
      k = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 7) == 0) k = K_UP | K_DOWN;
      step(i, k, 1'b0);
      if (m_pend[i] == 5'd0) begin
        idle_quiet(i, 3);
      end else begin
        while (m_pend[i] != 5'd0) begin
          apply(i, fr);
          if (fr) begin
            for (int s = 1; s < KP; s++)
              kplan[s] = ($urandom_range(0, 24) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
            serve(i, d, 0, 1'b1);
          end
        end
      end
    end
  endtask

  initial begin
    bit fr;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; kp[i] = 1'b0; km[i] = 1'b0; ku[i] = 1'b0;
      kd[i] = 1'b0; kf[i] = 1'b0; txd[i] = 1'b0;
      model_reset(i);
    end
    for (int s = 0; s < KP; s++) kplan[s] = 5'd0;
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    idle_quiet(0, 2);

    // Power on: tx_start three cycles after the key, known frame words.
    step(0, K_PW, 1'b0);
    check("flag_cycle_start", 64'(ts[0]), 64'd0);
    apply(0, fr);
    check("pwr_on_d35", 64'(d35[0]), 64'({3'd0, 1'b1, 2'd0, 2'b00, 4'd10, 23'h040052}));
    check("pwr_on_d32", 64'(d32[0]), 64'({28'h0002000, 4'hB}));
    serve(0, 50, 0, 1'b0);

    // Keys during a frame coalesce into exactly one follow-up frame.
    kplan[3] = K_MODE; kplan[6] = K_FAN; kplan[9] = K_FAN; kplan[12] = K_DOWN;
    key_frame(0, K_UP, 20);
    check("coalesced_pend", 64'(m_pend[0]), 64'(K_MODE | K_FAN | K_DOWN));
    apply(0, fr);
    check("coalesce_d35", 64'(d35[0]), 64'({3'd1, 1'b1, 2'd1, 2'b00, 4'd10, 23'h040052}));
    check("coalesce_d32", 64'(d32[0]), 64'({28'h0002000, 4'hD}));
    serve(0, 10, 0, 1'b0);
    idle_quiet(0, 5);

    // Temperature saturation at 30 still sends a frame; up+down together is ignored.
    for (int n = 0; n < 5; n++) key_frame(0, K_UP, int'($urandom_range(1, 20)));
    check("sat_temp", 64'(ctemp[0]), 64'd30);
    check("sat_tcode", 64'(d35[0][26:23]), 64'd14);
    step(0, K_UP | K_DOWN, 1'b0);
    idle_quiet(0, 4);
    check("updown_temp", 64'(ctemp[0]), 64'd30);

    // Power off, then keys while off: no frame, state unchanged.
    key_frame(0, K_PW, 15);
    step(0, K_MODE | K_UP, 1'b0);
    apply(0, fr);
    check("off_mode", 64'(cmode[0]), 64'd1);
    check("off_temp", 64'(ctemp[0]), 64'd30);
    idle_quiet(0, 3);

    // Timeout sets err_timeout; next good frame clears it.
    step(0, K_PW, 1'b0);
    apply(0, fr);
    serve(0, 0, 0, 1'b1);
    check("err_sticky", 64'(err_o[0]), 64'd1);
    key_frame(0, K_FAN, 7);
    check("err_cleared", 64'(err_o[0]), 64'd0);

    // REPEAT=3: three identical frames, then reset in the middle of frame 2.
    key_frame(1, K_PW, 20);
    step(1, K_MODE, 1'b0);
    apply(1, fr);
    serve(1, 12, 1, 1'b0);
    step(1, 5'd0, 1'b0);
    step(1, 5'd0, 1'b0);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    model_reset(1);
    check_reset(1);
    for (int c = 0; c < 30; c++) begin
      step(1, 5'd0, 1'($urandom_range(0, 1)));
      check("post_rst_start", 64'(ts[1]), 64'd0);
      check("post_rst_busy", 64'(busy_o[1]), 64'd0);
    end

    random_run(0, 50);
    random_run(1, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ac_ir_cmd_scheduler.md
Name: ac_ir_cmd_scheduler

Overview:
Front-end controller for the air-conditioner IR transmitter. It owns the AC state (power, mode, temperature, fan) and turns debounced key pulses into updates of that state. It builds the 35-bit and 32-bit frame words and sequences the transmitter through a start/done handshake. It also enforces repeat count, inter-frame gap and a done-timeout.

Parameters:
GAP_CYCLES, 12500000, idle clocks after each frame before the next tx_start (100 ms at 125 MHz)
TIMEOUT_CYCLES, 25000000, max clocks waiting for tx_done before abort (200 ms)
REPEAT, 1, frames sent per state update (1..7)
TEMP_RESET, 26, reset setpoint in °C (16..30)
CONST35, 23'h040052, fixed low field of data35
CONST32, 28'h0002000, fixed high field of data32

Ports:
clk  in  1  system clock (125 MHz)
rst  in  1  synchronous active-high reset
key_power  in  1  one-cycle pulse: toggle power
key_mode  in  1  one-cycle pulse: next mode
key_temp_up  in  1  one-cycle pulse: setpoint +1
key_temp_down  in  1  one-cycle pulse: setpoint -1
key_fan  in  1  one-cycle pulse: next fan speed
tx_start  out  1  one-cycle pulse: transmitter latches tx_data35/tx_data32
tx_data35  out  35  first frame word, MSB sent first
tx_data32  out  32  second frame word, MSB sent first
tx_done  in  1  one-cycle pulse from transmitter: last bit sent
busy  out  1  high in every state except IDLE
err_timeout  out  1  sticky: a frame got no tx_done in time
cur_power  out  1  current power state
cur_mode  out  3  current mode, 0..4
cur_temp  out  5  current setpoint in °C, 16..30
cur_fan  out  2  current fan speed, 0..3

Behaviour:
- Reset, and only reset, on a rising clk edge with rst=1. Values: power=0, mode=0, temp=TEMP_RESET, fan=0, all pending flags=0, tx_start=0, tx_data35=0, tx_data32=0, busy=0, err_timeout=0, state=IDLE, counters=0.
- Pending flags: one per key. A flag is set on the cycle after its key pulse, in any state. Keys arriving while busy are coalesced, never lost. A flag is cleared only in APPLY.
- If key_temp_up and key_temp_down pulse in the same cycle, both are ignored.
- IDLE: if any flag is pending, go to APPLY next cycle.
- APPLY (1 cycle): apply every pending flag at once, then clear all flags.
  - Order: power toggles first. If the resulting power=0, the other flags are discarded.
  - Mode: 0..4, wraps 4->0.
  - Temp: saturates at 30 going up and at 16 going down. A saturated update still produces a frame.
  - Fan: 0..3, wraps 3->0.
  - If power was 0 and only non-power flags are pending, they are discarded, no frame is sent, and the FSM returns to IDLE.
  - Otherwise load the repeat counter with REPEAT and go to LOAD.
- Frame encoding:
  - data35 = {mode[2:0], power, fan[1:0], 2'b00, tcode[3:0], CONST35}, with tcode = temp-16.
  - data32 = {CONST32, chk[3:0]}, with chk = (mode + power + fan + tcode) mod 16.
- LOAD (1 cycle): tx_data35/tx_data32 are registered and tx_start=1 in this cycle only. The data words hold stable until the next LOAD. Next state is WAIT_DONE.
- WAIT_DONE: a timeout counter starts at 0.
  - On tx_done: clear err_timeout, decrement the repeat counter, go to GAP.
  - If the counter reaches TIMEOUT_CYCLES-1 without tx_done: set err_timeout, force the repeat counter to 0, go to GAP.
- GAP: count GAP_CYCLES clocks, then go to LOAD if repeats remain, else IDLE. Frame data is not rebuilt between repeats.
- tx_done outside WAIT_DONE is ignored.
- Latency: key pulse at cycle N -> flag set at N+1 -> APPLY at N+2 -> tx_start at N+3, with cur_* updated from N+3.
- Reset mid-frame returns everything to reset values within one cycle. tx_start is never asserted on the reset cycle.

Test Plan:
(Bench overrides GAP_CYCLES=8, TIMEOUT_CYCLES=100, REPEAT=1.)
- Reset, then key_power pulse -> tx_start exactly 3 cycles later. tx_data35 = {3'd0,1'b1,2'd0,2'b00,4'd10,23'h040052}, tx_data32 = {28'h0002000,4'hB}, cur_power=1. tx_done 50 cycles later -> busy drops 8 cycles after tx_done.
- Power on, temp=30, key_temp_up -> frame sent with tcode=14 and cur_temp=30. Simultaneous up+down pulse -> no flag set, no frame.
- While WAIT_DONE: key_mode, then key_fan twice -> the fan flag is single (coalesced), so after GAP exactly one more frame is sent with mode=1, fan=1, chk=(1+1+1+10)=4'hD.
- Power off, then key_mode and key_temp_up -> no tx_start, cur_mode and cur_temp unchanged, busy drops after the 1-cycle APPLY.
- Withhold tx_done -> err_timeout=1 at 100 cycles in WAIT_DONE, busy drops after GAP. The next successful frame clears err_timeout.
- REPEAT=3 with tx_done each frame -> 3 tx_start pulses with identical data, each separated by tx_done+8 cycles. Assert rst during the second frame -> all outputs return to reset values next cycle, and no further tx_start occurs.
